// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and sizing helper for the fetch front end.
package fetch_pkg;

  localparam logic [11:0] HALT_MASK_DEF  = 12'hFFF;
  localparam logic [11:0] HALT_VALUE_DEF = 12'h300;
  localparam int          ADDR_W_DEF     = 32;
  localparam int          INSN_W_DEF     = 32;

  // Queue entry at the default widths; the top rebuilds the same layout
  // from its own parameters so non-default widths stay consistent.
  typedef struct packed {
    logic [INSN_W_DEF-1:0] insn;
    logic [ADDR_W_DEF-1:0] pcPlus4;
  } queueEntry_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush and occupancy count.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = cntWidth(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPop    = pop & ~empty & ~flush;
  assign doPush   = push & ~flush & (~full | doPop);
  assign headData = mem[rdPtr];

  // Pointer and occupancy bookkeeping; flush discards every entry at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch front end: credit-limited PC generator, in-flight address
// tracking, instruction queue to decode, redirect flush with stale-response
// discard, and halt-pattern detection.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INSN_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [11:0]       HALT_MASK  = HALT_MASK_DEF,
  parameter logic [11:0]       HALT_VALUE = HALT_VALUE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_valid,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              id_valid,
  output logic [INSN_W-1:0] id_insn,
  output logic [ADDR_W-1:0] id_pc_plus4,
  input  logic              id_ready,
  output logic              halted
);

  localparam int CW = cntWidth(DEPTH);

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [ADDR_W-1:0] pcPlus4;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     dropCnt;
  logic [CW-1:0]     qCount;
  logic [CW-1:0]     aCount;
  logic [CW:0]       credUsed;
  logic              haltSeen;
  logic              flush;
  logic [ADDR_W-1:0] flushTarget;
  logic              reqFire;
  logic              rspKeep;
  logic              qPush;
  logic              popFire;
  logic              qEmpty;
  logic              aEmpty;
  logic [ADDR_W-1:0] rspAddr;
  entry_t            pushEntry;
  entry_t            headEntry;
  logic              unusedAddrCount;

  function automatic logic isHalt(input logic [11:0] low);
    return (low & HALT_MASK) == HALT_VALUE;
  endfunction

  // Once halted nothing may disturb the frozen state, so flushes are masked.
  assign flush       = (start_valid | redirect_valid) & ~halted;
  assign flushTarget = start_valid ? start_addr : redirect_target;

  // Queue occupancy plus requests in flight can never exceed DEPTH, which
  // is what guarantees every response has a queue slot waiting for it.
  assign credUsed       = {1'b0, qCount} + {1'b0, outstanding};
  assign imem_req_valid = reset_n & ~haltSeen & ~halted & ~flush
                        & (credUsed < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign reqFire        = imem_req_valid & imem_req_ready;

  // Responses owed to a flushed stream are consumed by dropCnt first.
  assign rspKeep = imem_rsp_valid & (dropCnt == '0) & ~flush & ~aEmpty;
  assign qPush   = rspKeep & ~halted;

  assign pushEntry.insn    = imem_rsp_data;
  assign pushEntry.pcPlus4 = rspAddr + ADDR_W'(4);

  assign id_valid    = ~qEmpty;
  assign popFire     = id_valid & id_ready;
  assign id_insn     = qEmpty ? '0 : headEntry.insn;
  assign id_pc_plus4 = qEmpty ? '0 : headEntry.pcPlus4;

  assign unusedAddrCount = ^aCount;

  // PC, credit and discard accounting plus halt tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_ADDR;
      outstanding <= '0;
      dropCnt     <= '0;
      haltSeen    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(reqFire) - CW'(imem_rsp_valid);
      if (flush) begin
        pc       <= flushTarget;
        dropCnt  <= outstanding - CW'(imem_rsp_valid);
        haltSeen <= 1'b0;
      end else begin
        if (reqFire) pc <= pc + ADDR_W'(4);
        if (imem_rsp_valid && dropCnt != '0) dropCnt <= dropCnt - CW'(1);
        if (qPush && isHalt(imem_rsp_data[11:0])) haltSeen <= 1'b1;
      end
      if (popFire && isHalt(headEntry.insn[11:0])) halted <= 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) entryQueue (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (qPush),
    .pushData (pushEntry),
    .pop      (popFire),
    .headData (headEntry),
    .empty    (qEmpty),
    .count    (qCount)
  );

  // Addresses of live (non-discarded) requests, in issue order.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) addrQueue (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (reqFire),
    .pushData (pc),
    .pop      (rspKeep),
    .headData (rspAddr),
    .empty    (aEmpty),
    .count    (aCount)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit with a variable-latency memory model.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_valid;
  logic [31:0] start_addr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_insn;
  logic [31:0] id_pc_plus4;
  logic        id_ready;
  logic        halted;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .ADDR_W     (32),
    .INSN_W     (32),
    .DEPTH      (4),
    .RESET_ADDR (32'h100),
    .HALT_MASK  (12'hFFF),
    .HALT_VALUE (12'h300)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_valid     (start_valid),
    .start_addr      (start_addr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_valid        (id_valid),
    .id_insn         (id_insn),
    .id_pc_plus4     (id_pc_plus4),
    .id_ready        (id_ready),
    .halted          (halted)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct { int due; logic [31:0] addr; logic [31:0] data; } memReq_t;
  typedef struct { logic [31:0] insn; logic [31:0] pcp4; } exp_t;

  memReq_t     memQ[$];
  exp_t        sbQ[$];
  logic [31:0] reqLog[$];
  int          cyc = 0;
  int          memLat = 1;
  int          lastDue = 0;
  int          popCount = 0;
  logic        haltEn = 1'b0;
  logic        haltedExp = 1'b0;
  logic        haltNext = 1'b0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    logic [11:0] low;
    low = (haltEn && a == 32'h20) ? 12'h300 : 12'h0A5;
    return {a[21:2], low};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: in-order responses memLat cycles after acceptance
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memQ[0].data;
        void'(memQ.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // monitor: checks dequeues against the scoreboard, records requests
  initial begin
    exp_t        e;
    memReq_t     m;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        checkVal("halted", halted, haltedExp);
        if (id_valid && id_ready) begin
          popCount++;
          checkVal("pop_expected", sbQ.size() > 0, 1);
          if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal("id_insn", id_insn, e.insn);
            checkVal("id_pc_plus4", id_pc_plus4, e.pcp4);
            if (e.insn[11:0] == 12'h300) haltNext = 1'b1;
          end
        end
        if ((start_valid || redirect_valid) && !haltedExp) sbQ.delete();
        if (imem_req_valid && imem_req_ready) begin
          m.addr = imem_req_addr;
          m.data = memData(imem_req_addr);
          m.due  = cyc + memLat;
          if (m.due <= lastDue) m.due = lastDue + 1;
          lastDue = m.due;
          memQ.push_back(m);
          sbQ.push_back('{insn: m.data, pcp4: imem_req_addr + 32'd4});
          reqLog.push_back(imem_req_addr);
        end
        haltedExp = haltedExp | haltNext;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  int          found;
  int          t0;
  int          p0;
  int          maxSb;
  int          logIdx;
  int          r;
  logic [31:0] tgt;
  logic [31:0] st;
  logic [31:0] expTgt;
  logic [31:0] maxA;

  initial begin
    reset_n = 1'b0; start_valid = 0; start_addr = '0; redirect_valid = 0;
    redirect_target = '0; imem_req_ready = 1; id_ready = 1;
    repeat (2) stepCycle();
    checkVal("rst_req_valid", imem_req_valid, 0);
    checkVal("rst_req_addr", imem_req_addr, 32'h100);
    checkVal("rst_id_valid", id_valid, 0);
    checkVal("rst_id_insn", id_insn, 0);
    checkVal("rst_id_pc_plus4", id_pc_plus4, 0);
    checkVal("rst_halted", halted, 0);

    // reset release, L=1
    reset_n = 1'b1;
    #1;
    checkVal("first_req_valid", imem_req_valid, 1);
    checkVal("first_req_addr", imem_req_addr, 32'h100);
    stepCycle();
    stepCycle();
    checkVal("first_id_valid", id_valid, 1);
    checkVal("first_pc_plus4", id_pc_plus4, 32'h104);
    p0 = popCount;
    repeat (8) stepCycle();
    checkVal("throughput_l1", popCount - p0, 8);

    // decode stall, L=2
    memLat = 2; id_ready = 0; maxSb = 0;
    repeat (10) begin
      stepCycle();
      if (sbQ.size() > maxSb) maxSb = sbQ.size();
    end
    checkVal("stall_credit_max", maxSb, 4);
    checkVal("stall_buffered", sbQ.size(), 4);
    checkVal("stall_mem_idle", memQ.size(), 0);
    checkVal("stall_id_valid", id_valid, 1);
    checkVal("stall_req_valid", imem_req_valid, 0);
    id_ready = 1;
    repeat (12) stepCycle();

    // redirect with 3 requests in flight, L=3
    memLat = 3; found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      stepCycle();
      if (memQ.size() + imem_rsp_valid == 3) found = 1;
    end
    checkVal("redir_wait_3_outstanding", found, 1);
    redirect_valid = 1; redirect_target = 32'h400; t0 = cyc;
    #1;
    checkVal("redir_no_req", imem_req_valid, 0);
    stepCycle();
    redirect_valid = 0;
    #1;
    checkVal("redir_req_valid", imem_req_valid, 1);
    checkVal("redir_req_addr", imem_req_addr, 32'h400);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      stepCycle();
      if (id_valid) found = 1;
    end
    checkVal("redir_id_wait", found, 1);
    checkVal("redir_pc_plus4", id_pc_plus4, 32'h404);
    checkVal("redir_latency", cyc - t0, 5);
    repeat (6) stepCycle();

    // redirect coinciding with a response and a head handshake
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      stepCycle();
      if (imem_rsp_valid && id_valid && (memQ.size() + 1 >= 2)) found = 1;
    end
    checkVal("coinc_wait", found, 1);
    redirect_valid = 1; redirect_target = 32'h600;
    stepCycle();
    redirect_valid = 0;
    #1;
    checkVal("coinc_req_addr", imem_req_addr, 32'h600);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      stepCycle();
      if (id_valid) found = 1;
    end
    checkVal("coinc_id_wait", found, 1);
    checkVal("coinc_pc_plus4", id_pc_plus4, 32'h604);

    // random backpressure and flushes, L=2
    memLat = 2;
    for (int i = 0; i < 200; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        r   = $urandom_range(0, 3);
        tgt = 32'h1000 + ($urandom_range(0, 255) << 2);
        st  = 32'h2000 + ($urandom_range(0, 255) << 2);
        redirect_valid = (r != 0);
        start_valid    = (r != 1);
        redirect_target = tgt;
        start_addr      = st;
        expTgt = (r != 1) ? st : tgt;
        stepCycle();
        redirect_valid = 0; start_valid = 0;
        #1;
        checkVal("rand_flush_target", imem_req_addr, expTgt);
      end else begin
        stepCycle();
      end
    end
    id_ready = 1; imem_req_ready = 1;
    repeat (15) stepCycle();

    // halt pattern at 0x20, L=1
    memLat = 1; haltEn = 1;
    start_addr = 32'h0; start_valid = 1; logIdx = reqLog.size();
    stepCycle();
    start_valid = 0;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      stepCycle();
      if (halted) found = 1;
    end
    checkVal("halt_reached", found, 1);
    maxA = '0;
    for (int i = logIdx; i < reqLog.size(); i++) if (reqLog[i] > maxA) maxA = reqLog[i];
    checkVal("halt_last_req", maxA, 32'h24);
    repeat (3) stepCycle();
    checkVal("halt_no_req", imem_req_valid, 0);
    redirect_valid = 1; redirect_target = 32'h500;
    stepCycle();
    redirect_valid = 0;
    #1;
    checkVal("halt_redir_ignored_valid", imem_req_valid, 0);
    checkVal("halt_redir_ignored_addr", imem_req_addr, 32'h28);
    checkVal("halt_sticky", halted, 1);
    repeat (3) stepCycle();
    checkVal("halt_sb_drained", sbQ.size(), 0);
    checkVal("halt_mem_idle", memQ.size(), 0);

    // reset clears halt; PC wraps past the top of the address space
    reset_n = 0;
    memQ.delete(); sbQ.delete(); lastDue = 0;
    haltedExp = 0; haltNext = 0; haltEn = 0;
    repeat (2) stepCycle();
    checkVal("rst2_halted", halted, 0);
    checkVal("rst2_req_addr", imem_req_addr, 32'h100);
    reset_n = 1; start_valid = 1; start_addr = 32'hFFFF_FFF8; logIdx = reqLog.size();
    stepCycle();
    start_valid = 0;
    repeat (8) stepCycle();
    checkVal("wrap_req_count", reqLog.size() >= logIdx + 3, 1);
    if (reqLog.size() >= logIdx + 3) begin
      checkVal("wrap_req0", reqLog[logIdx], 32'hFFFF_FFF8);
      checkVal("wrap_req1", reqLog[logIdx+1], 32'hFFFF_FFFC);
      checkVal("wrap_req2", reqLog[logIdx+2], 32'h0000_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised decoupled fetch front end: a PC generator that issues requests to an instruction memory with arbitrary, in-order response latency, and a DEPTH-entry instruction queue feeding decode through a valid/ready handshake. Sits between the instruction memory and the ID stage, replacing the single-cycle fetch path. Adds credit-based prefetch, flush-on-redirect with in-flight response discard, and halt-pattern detection that stops fetching cleanly.

## Interface
- ADDR_W, 32, PC/address width
- INSN_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_ADDR, 0, PC after reset
- HALT_MASK, 12'hFFF, bits of insn[11:0] compared
- HALT_VALUE, 12'h300, halt pattern on masked insn[11:0]

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_valid  in  1  load start_addr as new PC (treated as redirect)
- start_addr  in  ADDR_W  program start address
- redirect_valid  in  1  branch/jump taken in ID; flush and refetch
- redirect_target  in  ADDR_W  resolved target
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  ADDR_W  fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  in-order response, ≥1 cycle after acceptance
- imem_rsp_data  in  INSN_W  instruction
- id_valid  out  1  queue head valid
- id_insn  out  INSN_W  head instruction
- id_pc_plus4  out  ADDR_W  head PC + 4
- id_ready  in  1  decode accepts head (low = stall)
- halted  out  1  halt instruction consumed by decode; sticky

## Operation
- Reset: pc=RESET_ADDR, queue empty, outstanding=0, drop=0, halt_seen=0, halted=0; all outputs low/zero except imem_req_addr=RESET_ADDR. Fetching starts the first cycle after reset release.
- Issue: imem_req_valid = ~halt_seen & ~halted & ~flush & (count + outstanding < DEPTH), where flush = redirect_valid | start_valid. On req handshake pc ← pc+4 (mod 2^ADDR_W), outstanding+1.
- Response: outstanding−1. If drop>0: discard, drop−1. Else push {data, addr+4} into queue (addresses tracked by an internal DEPTH-deep in-flight address FIFO). Credit rule guarantees no overflow.
- Halt: pushed insn with (insn[11:0]&HALT_MASK)==HALT_VALUE sets halt_seen; issue stops. Later non-dropped responses are still enqueued behind it. halted sets the cycle after the halt insn is dequeued (id_valid&id_ready); further responses discarded.
- Flush (redirect_valid or start_valid; start_addr wins if both): queue emptied, pc ← target, halt_seen←0, drop ← outstanding − imem_rsp_valid, no request that cycle. A head handshake in the same cycle counts as consumed. Flush is ignored once halted; only reset clears halted.
- Dequeue: id_valid = ~empty; head popped on id_valid&id_ready.

## Timing
- Request to id_valid: memory latency L + 1 cycle (queue is registered; no bypass).
- Redirect at cycle t: req at t+1 with target, id_valid at earliest t+2+L.
- Sustained throughput 1 insn/cycle when L ≤ DEPTH−1 and id_ready high.
- Simultaneous push and pop on a full queue allowed; push and flush same cycle: flush wins, data dropped.
- Reset asserted mid-operation: all state clears immediately; responses from pre-reset requests are the environment's responsibility to suppress.

## Structure
- Package fetch_pkg: halt default constants, typedef for queue entry {insn, pc_plus4}, helper for clog2(DEPTH)+1 counter width.
- Sub-module fetch_fifo: parametrised synchronous FIFO with flush, count output; instanced twice (entry queue, in-flight address FIFO).

## Test plan
- Reset release, L=1, id_ready=1, RESET_ADDR=0x100 -> requests 0x100,0x104,…; id_pc_plus4 0x104 at cycle 3, one per cycle after.
- id_ready low 10 cycles, DEPTH=4, L=2 -> exactly 4 insns buffered, count+outstanding never >4, imem_req_valid low, no loss on release.
- L=3, redirect to 0x400 with 3 outstanding -> 3 responses discarded, next id_pc_plus4=0x404, no stale insn visible.
- Response with insn[11:0]=0x300 at 0x20 -> no further requests; halted high cycle after its dequeue; redirect afterwards ignored.
- Redirect coinciding with imem_rsp_valid and head handshake -> response dropped, head counted consumed, drop=outstanding−1.
- pc=0xFFFFFFFC fetch -> next request 0x00000000, id_pc_plus4=0x00000000.
